// File: rtl/truth_table_sweeper.sv
// Exhaustively drives all eight input vectors of a 3-input circuit, captures z for each,
// and compares the captured truth table against a golden table latched at sweep start.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       z,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [3:0] mismatch_cnt,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [2:0] index;
    logic [3:0] wait_cnt;
    logic [7:0] expected_q;
    logic       miss;
    logic [3:0] mismatch_next;

    assign miss          = z ^ expected_q[index];
    assign mismatch_next = mismatch_cnt + {3'b000, miss};

    // NOTE: every register here is updated with <= so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            index        <= 3'd0;
            wait_cnt     <= 4'd0;
            expected_q   <= 8'h00;
            {x1, x2, x3} <= 3'b000;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= 8'h00;
            mismatch_cnt <= 4'd0;
            pass         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        expected_q   <= expected;
                        table_out    <= 8'h00;
                        mismatch_cnt <= 4'd0;
                        pass         <= 1'b0;
                        index        <= 3'd0;
                        wait_cnt     <= 4'd0;
                        {x1, x2, x3} <= 3'b000;
                        busy         <= 1'b1;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    table_out[index] <= z;
                    mismatch_cnt     <= mismatch_next;
                    if (index == 3'd7) begin
                        // Final count is known here, so pass is valid alongside done.
                        pass         <= (mismatch_next == 4'd0);
                        done         <= 1'b1;
                        {x1, x2, x3} <= 3'b000;
                        state        <= DONE;
                    end else begin
                        index        <= index + 3'd1;
                        {x1, x2, x3} <= index + 3'd1;
                        wait_cnt     <= 4'd0;
                        state        <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised scoreboard bench: stimulus pushes model-derived expectations,
// a negedge monitor pops and compares them whenever done is seen.
module tb_truth_table_sweeper;

    localparam int S_A = 2;
    localparam int S_B = 1;
    localparam int SWEEP_A = 8 * (S_A + 1);

    typedef struct {
        logic [7:0] tbl;
        int         cnt;
        logic       pass;
        int         done_cycle;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst;
    logic       start_a, start_b;
    logic [7:0] exp_a, exp_b;
    logic       z_a, z_b;
    logic       x1_a, x2_a, x3_a, x1_b, x2_b, x3_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [7:0] table_a, table_b;
    logic [3:0] cnt_a, cnt_b;
    int         mode_a;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t last_it;
    int   sweep_acc = -1;
    int   done_b_cycles[$];

    // Reference circuits under test, described directly by their Boolean rules.
    function automatic logic circuit(int mode, logic [2:0] v);
        case (mode)
            0:       return (int'(v[2]) + int'(v[1]) + int'(v[0])) >= 2;
            1:       return ^v;
            2:       return &v;
            default: return v[2] | (v[1] & ~v[0]);
        endcase
    endfunction

    function automatic exp_t model(int mode, logic [7:0] e);
        exp_t r;
        r.tbl = 8'h00;
        r.cnt = 0;
        for (int v = 0; v < 8; v++) begin
            r.tbl[v] = circuit(mode, 3'(v));
            if (r.tbl[v] != e[v]) r.cnt++;
        end
        r.pass = (r.cnt == 0);
        r.done_cycle = 0;
        return r;
    endfunction

    assign z_a = circuit(mode_a, {x1_a, x2_a, x3_a});
    assign z_b = circuit(0, {x1_b, x2_b, x3_b});

    truth_table_sweeper #(.SETTLE_CYCLES(S_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(exp_a), .z(z_a),
        .x1(x1_a), .x2(x2_a), .x3(x3_a), .busy(busy_a), .done(done_a),
        .table_out(table_a), .mismatch_cnt(cnt_a), .pass(pass_a)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(S_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(exp_b), .z(z_b),
        .x1(x1_b), .x2(x2_b), .x3(x3_b), .busy(busy_b), .done(done_b),
        .table_out(table_b), .mismatch_cnt(cnt_b), .pass(pass_b)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares sweep results on done, and the vector sequence while running.
    always @(negedge clk) begin
        exp_t it;
        int   k;
        if (done_a) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done_a), 32'd0);
            end else begin
                it = sb.pop_front();
                check("table_out", 32'(table_a), 32'(it.tbl));
                check("mismatch_cnt", 32'(cnt_a), 32'(it.cnt));
                check("pass", 32'(pass_a), 32'(it.pass));
                check("done_cycle", 32'(cyc), 32'(it.done_cycle));
                check("x_in_done", 32'({x1_a, x2_a, x3_a}), 32'd0);
            end
        end else if (sb.size() > 0 && cyc > sb[0].done_cycle) begin
            it = sb.pop_front();
            check("done_timeout", 32'(done_a), 32'd1);
        end
        if (sweep_acc >= 0) begin
            k = cyc - sweep_acc;
            if (k >= 0 && k < SWEEP_A) begin
                check("x_vector", 32'({x1_a, x2_a, x3_a}), 32'(k / (S_A + 1)));
                check("busy_run", 32'(busy_a), 32'd1);
            end
        end
    end

    always @(negedge clk) if (done_b) done_b_cycles.push_back(cyc);

    // Issue one sweep on dut_a from a negedge; returns on the first IDLE cycle after DONE.
    task automatic sweep_a(int mode, logic [7:0] e, bit poke);
        exp_t it;
        mode_a  = mode;
        exp_a   = e;
        start_a = 1'b1;
        it = model(mode, e);
        it.done_cycle = cyc + 1 + SWEEP_A;
        sb.push_back(it);
        last_it   = it;
        sweep_acc = cyc + 1;
        @(negedge clk);
        start_a = 1'b0;
        exp_a   = poke ? ~e : 8'($urandom);
        if (poke) begin
            repeat (4) @(negedge clk);
            start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            repeat (SWEEP_A - 4) @(negedge clk);
        end else begin
            repeat (SWEEP_A + 1) @(negedge clk);
        end
    endtask

    initial begin
        int c0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        exp_a = 8'h00; exp_b = 8'hE8; mode_a = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_x", 32'({x1_a, x2_a, x3_a}), 32'd0);
        check("rst_table", 32'(table_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Short settle, start held high: two sweeps back to back.
        c0 = cyc;
        start_b = 1'b1;
        repeat (36) @(negedge clk);
        start_b = 1'b0;
        check("b_done_count", 32'(done_b_cycles.size()), 32'd2);
        if (done_b_cycles.size() == 2) begin
            check("b_done_1", 32'(done_b_cycles[0]), 32'(c0 + 17));
            check("b_done_2", 32'(done_b_cycles[1]), 32'(c0 + 35));
        end
        check("b_table", 32'(table_b), 32'hE8);
        check("b_pass", 32'(pass_b), 32'd1);

        sweep_a(0, 8'hE8, 1'b1);
        sweep_a(1, 8'h96, 1'b0);
        sweep_a(2, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            sweep_a(int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset ten cycles into a sweep: aborts without done.
        sweep_acc = -1;
        mode_a = 0; exp_a = 8'h00; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_x", 32'({x1_a, x2_a, x3_a}), 32'd0);
        check("abort_table", 32'(table_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        repeat (30) @(negedge clk);

        sweep_a(3, 8'($urandom), 1'b0);
        repeat (5) @(negedge clk);
        check("hold_table", 32'(table_a), 32'(last_it.tbl));
        check("hold_cnt", 32'(cnt_a), 32'(last_it.cnt));
        check("hold_pass", 32'(pass_a), 32'(last_it.pass));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
